// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] rsData,
    input  logic [DATA_WIDTH-1:0] rtData,
    input  logic                  writeHi,
    input  logic                  writeLo,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic                  busy,
    output logic                  done,
    output logic                  divByZero,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] c_LAST = CW'(W - 1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_CALC = 2'd1;
    localparam logic [1:0] c_S_FIX  = 2'd2;

    logic [1:0]     r_state;
    logic [1:0]     w_state_nxt;
    logic [CW-1:0]  r_cnt;
    logic [2*W-1:0] r_acc;
    logic [W-1:0]   r_opb;
    logic           r_is_div;
    logic           r_neg_q;
    logic           r_neg_r;
    logic [W-1:0]   r_hi;
    logic [W-1:0]   r_lo;
    logic           r_busy;
    logic           r_done;
    logic           r_dbz;

    logic           w_done_nxt;
    logic           w_dbz_nxt;
    logic           w_divzero;
    logic           w_accept;
    logic           w_signed;
    logic [W-1:0]   w_mag_rs;
    logic [W-1:0]   w_mag_rt;
    logic [W:0]     w_mul_sum;
    logic [2*W-1:0] w_mul_step;
    logic [W:0]     w_div_shift;
    logic [W+1:0]   w_div_diff;
    logic [2*W-1:0] w_div_step;
    logic [2*W-1:0] w_fix;

    assign w_divzero = op[1] && (rtData == '0);
    assign w_accept  = start && !w_divzero;
    assign w_signed  = !op[0];
    // Magnitudes: the most negative value maps onto unsigned 2^(W-1).
    assign w_mag_rs  = (w_signed && rsData[W-1]) ? (~rsData + 1'b1) : rsData;
    assign w_mag_rt  = (w_signed && rtData[W-1]) ? (~rtData + 1'b1) : rtData;

    // Shift-add: multiplier sits in the low half and is consumed LSB first.
    assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    assign w_mul_step = {w_mul_sum, r_acc[W-1:1]};

    // Restoring divide: remainder in the high half, quotient shifts into the low half.
    assign w_div_shift = {r_acc[2*W-1:W], r_acc[W-1]};
    assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_opb};
    assign w_div_step  = w_div_diff[W+1]
                       ? {w_div_shift[W-1:0], r_acc[W-2:0], 1'b0}
                       : {w_div_diff[W-1:0],  r_acc[W-2:0], 1'b1};

    always_comb begin
        w_fix = r_acc;
        if (r_is_div) begin
            w_fix[2*W-1:W] = r_neg_r ? (~r_acc[2*W-1:W] + 1'b1) : r_acc[2*W-1:W];
            w_fix[W-1:0]   = r_neg_q ? (~r_acc[W-1:0] + 1'b1)   : r_acc[W-1:0];
        end else if (r_neg_q) begin
            w_fix = ~r_acc + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: if (w_accept) w_state_nxt = c_S_CALC;
            c_S_CALC: if (r_cnt == c_LAST) w_state_nxt = c_S_FIX;
            c_S_FIX:  w_state_nxt = c_S_IDLE;
            default:  w_state_nxt = c_S_IDLE;
        endcase
    end

    always_comb begin
        w_done_nxt = 1'b0;
        w_dbz_nxt  = 1'b0;
        if (r_state == c_S_FIX) begin
            w_done_nxt = 1'b1;
        end else if ((r_state == c_S_IDLE) && start && w_divzero) begin
            w_done_nxt = 1'b1;
            w_dbz_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != c_S_IDLE);
            r_done <= w_done_nxt;
            r_dbz  <= w_dbz_nxt;
            case (r_state)
                c_S_IDLE: begin
                    if (w_accept) begin
                        r_cnt    <= '0;
                        r_is_div <= op[1];
                        r_acc    <= {{W{1'b0}}, (op[1] ? w_mag_rs : w_mag_rt)};
                        r_opb    <= op[1] ? w_mag_rt : w_mag_rs;
                        r_neg_q  <= w_signed && (rsData[W-1] ^ rtData[W-1]);
                        r_neg_r  <= w_signed && rsData[W-1];
                    end else if (!start) begin
                        if (writeHi) r_hi <= writeData;
                        if (writeLo) r_lo <= writeData;
                    end
                end
                c_S_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    r_acc <= r_is_div ? w_div_step : w_mul_step;
                end
                c_S_FIX: begin
                    r_hi <= w_fix[2*W-1:W];
                    r_lo <= w_fix[W-1:0];
                end
                default: ;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign divByZero = r_dbz;
    assign hi        = r_hi;
    assign lo        = r_lo;

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath. Sits directly downstream of the register file: it consumes the `$rs`/`$rt` read data (`outputData1`/`outputData2`) for MULT/MULTU/DIV/DIVU and holds the 64-bit result in HI/LO. MFHI/MFLO read HI/LO, and the value returns to the register file through the writeback mux. Operations are multi-cycle, so the control unit stalls on `busy`.

## Interface
- `DATA_WIDTH`, 32, operand/HI/LO width; the iteration count equals `DATA_WIDTH`.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clock`.
- `start`  in  1  request a new operation; sampled only in IDLE.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`.
- `rsData`  in  DATA_WIDTH  dividend / multiplicand (register file `outputData1`).
- `rtData`  in  DATA_WIDTH  divisor / multiplier (register file `outputData2`).
- `writeHi`  in  1  MTHI: load `writeData` into HI; honoured only in IDLE.
- `writeLo`  in  1  MTLO: load `writeData` into LO; honoured only in IDLE.
- `writeData`  in  DATA_WIDTH  MTHI/MTLO data (`$rs`).
- `busy`  out  1  high while an operation is in flight (state ≠ IDLE).
- `done`  out  1  one-cycle pulse when an operation completes.
- `divByZero`  out  1  one-cycle pulse, coincident with `done`, for DIV/DIVU with `rtData` = 0.
- `hi`  out  DATA_WIDTH  HI register (product upper word / remainder).
- `lo`  out  DATA_WIDTH  LO register (product lower word / quotient).

## Operation
- **States:** IDLE, CALC, FIX. All outputs are registered.
- **IDLE + `start`, normal operation**
  - Capture the operand magnitudes. Signed ops take the two's-complement absolute value; 0x80000000 is kept as unsigned 2^31.
  - Record the result sign flags. Product sign = sign(rs) XOR sign(rt). Quotient sign = the same XOR. Remainder sign = sign(rs).
  - Clear the iteration counter and go to CALC.
- **IDLE + `start`, DIV/DIVU with `rtData` = 0**
  - No iteration; stay in IDLE.
  - Pulse `done` and `divByZero` next cycle. HI/LO are unchanged.
- **CALC:** one iteration per cycle, `DATA_WIDTH` iterations.
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring shift-subtract; quotient builds into LO, partial remainder into HI.
  - After iteration `DATA_WIDTH`−1, go to FIX.
- **FIX:** apply the sign correction, write HI/LO, set `done` = 1, go to IDLE.
  - MULT: negate the full 64-bit product if the product sign is negative.
  - DIV: negate the quotient and/or remainder per their flags.
  - Unsigned ops: no correction.
- **Arithmetic:** all results wrap modulo 2^32 per word. DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0, with no flag.
- **MTHI/MTLO:** in IDLE, `writeHi`/`writeLo` load `writeData` on the edge. Both may be asserted together. While `busy`, they are ignored.
- **Priority:** `start` together with `writeHi`/`writeLo` in the same IDLE cycle means `start` wins and the write is dropped.
- **`start` while busy:** ignored. No queuing, and captured operands are unaffected.

## Timing
- **Reset:** synchronous `reset` has priority over everything, in any state including mid-CALC/FIX.
  - Next edge: state = IDLE, counter = 0.
  - `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, `divByZero` = 0.
  - An aborted operation writes nothing.
- **Normal latency:** `start` sampled at edge E0.
  - `busy` = 1 after E0.
  - CALC iterates on E1..E32; FIX occupies E33.
  - After E33: HI/LO hold the result, `done` = 1 for one cycle, `busy` = 0.
  - Total: 33 cycles, start to result.
- **Divide-by-zero latency:** `done` and `divByZero` are high for the one cycle after E0; `busy` never rises.
- **Back-to-back:** `start` is accepted in the same cycle that `done` is high, because the unit is already in IDLE.
- **Hazard rule:** HI/LO never change except on a FIX edge, an honoured MTHI/MTLO edge, or reset. MFHI during `busy` reads the old value; stalling is the control unit's responsibility.

## Test plan
- **Reset then MULT:** reset 1 cycle, then MULT rs = 0xFFFFFFFE, rt = 3 → after 33 cycles, `done` pulse, HI = 0xFFFFFFFF, LO = 0xFFFFFFFA. `busy` is high for exactly 33 cycles.
- **MULTU max operands:** MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001.
- **Unsigned and signed divide:**
  - DIVU 100 / 7 → LO = 14, HI = 2.
  - DIV −7 (0xFFFFFFF9) / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- **Divide by zero:** MTHI 0x11, MTLO 0x22, then DIV 5 / 0 → next cycle `done` = `divByZero` = 1, `busy` stays 0, HI/LO remain 0x11/0x22.
- **Reset mid-operation:** MULTU 3 × 4, assert reset at cycle 10 → all outputs 0 next cycle, no `done` pulse. A following MULTU 3 × 4 gives LO = 12, HI = 0.
- **Busy-time inputs and back-to-back:**
  - During CALC, pulse `start` with new operands and `writeHi` = 1 → both ignored; result matches the original operands.
  - `start` in the `done` cycle is accepted immediately.
  - `start` + `writeLo` in the same IDLE cycle → the MTLO is dropped.
